// File: rtl/status_led_ctrl.sv
// rtl/status_led_ctrl.sv - input sync/debounce with reductions and rise events, prescaled LED pattern generator
module status_led_ctrl #(
    parameter int N_IN    = 4,
    parameter int N_LED   = 2,
    parameter int DEB_LEN = 16,
    parameter int PRESC   = 2097152
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in,
    input  logic [1:0]       mode,
    output logic             all_hi,
    output logic             any_hi,
    output logic [N_IN-1:0]  rise_evt,
    output logic             tick,
    output logic [N_LED-1:0] led
);

    localparam int CW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam int PW = $clog2(PRESC);
    localparam int SW = (N_LED > 3) ? N_LED : 3;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_LEN - 1);
    localparam logic [PW-1:0] P_MAX   = PW'(PRESC - 1);

    typedef enum logic [1:0] {COUNT = 2'd0, WALK = 2'd1, MIRROR = 2'd2, HEART = 2'd3} state_t;

    logic [N_IN-1:0] s1, s2, deb, deb_prev;
    logic [CW-1:0]   cnt [N_IN];

    state_t          state, state_next;
    logic [PW-1:0]   pcnt, pcnt_next;
    logic [SW-1:0]   step, step_next, step_inc;
    logic [N_LED-1:0] led_next, mirror, entry_led;
    logic            tick_next, wrap;
    logic [N_IN+N_LED-1:0] deb_ext;

    // A channel only follows s2 after DEB_LEN consecutive mismatching cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            deb      <= '0;
            deb_prev <= '0;
            all_hi   <= 1'b0;
            any_hi   <= 1'b0;
            rise_evt <= '0;
            for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
        end else begin
            s1       <= in;
            s2       <= s1;
            deb_prev <= deb;
            all_hi   <= &deb;
            any_hi   <= |deb;
            rise_evt <= deb & ~deb_prev;
            for (int i = 0; i < N_IN; i++) begin
                if (s2[i] != deb[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        deb[i] <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= state_t'(mode);
        else     state <= state_next;
    end

    always_comb begin
        state_next = state_t'(mode);
    end

    assign deb_ext   = {{N_LED{1'b0}}, deb};
    assign mirror    = deb_ext[N_LED-1:0];
    assign entry_led = (mode == WALK) ? N_LED'(1) : '0;
    assign wrap      = (pcnt == P_MAX);
    assign step_inc  = step + SW'(1);

    // A mode change restarts the pattern and swallows any tick due that cycle
    always_comb begin
        pcnt_next = wrap ? '0 : pcnt + PW'(1);
        tick_next = wrap;
        step_next = step;
        led_next  = led;
        if (state_next != state) begin
            pcnt_next = '0;
            tick_next = 1'b0;
            step_next = '0;
            led_next  = entry_led;
        end else begin
            if (wrap) step_next = step_inc;
            case (state)
                COUNT:  if (wrap) led_next = step_inc[N_LED-1:0];
                WALK:   if (wrap) led_next = (led << 1) | (led >> (N_LED - 1));
                MIRROR: led_next = mirror;
                HEART:  if (wrap) led_next = (step[2:0] == 3'd0 || step[2:0] == 3'd2) ? '1 : '0;
                default: led_next = led;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            step <= '0;
            tick <= 1'b0;
            led  <= entry_led;
        end else begin
            pcnt <= pcnt_next;
            step <= step_next;
            tick <= tick_next;
            led  <= led_next;
        end
    end

endmodule

// File: tb/tb_status_led_ctrl.sv
// tb/tb_status_led_ctrl.sv - directed and randomized checks of status_led_ctrl against a behavioural model
module tb_status_led_ctrl;

    localparam int N_IN = 4, N_LED = 2, DEB_LEN = 4, PRESC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_IN-1:0] in = '0;
    logic [1:0] mode = 2'd0;
    logic all_hi, any_hi, tick;
    logic [N_IN-1:0] rise_evt;
    logic [N_LED-1:0] led;

    int vectors = 0;
    int miscompares = 0;

    status_led_ctrl #(.N_IN(N_IN), .N_LED(N_LED), .DEB_LEN(DEB_LEN), .PRESC(PRESC)) dut (
        .clk(clk), .rst(rst), .in(in), .mode(mode), .all_hi(all_hi), .any_hi(any_hi),
        .rise_evt(rise_evt), .tick(tick), .led(led)
    );

    always #5 clk = ~clk;

    // Model: synchroniser as a delay line, debounce as "value held for DEB_LEN
    // samples", pattern as a function of cycles elapsed since the last entry.
    logic [N_IN-1:0] m_s1, m_s2, m_s2_last, m_deb, m_deb_prev, m_rise;
    logic [N_LED-1:0] m_led;
    logic m_all, m_any, m_tick;
    int age [N_IN];
    int m_state, c;

    task automatic model_edge();
        logic [N_IN-1:0] deb_old;
        int k, ph;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_s2_last = '0; m_deb = '0; m_deb_prev = '0; m_rise = '0;
            m_all = 0; m_any = 0; m_tick = 0;
            for (int i = 0; i < N_IN; i++) age[i] = 0;
            m_state = int'(mode); c = 0;
            m_led = (mode == 2'd1) ? N_LED'(1) : '0;
            return;
        end
        deb_old = m_deb;
        m_rise = m_deb & ~m_deb_prev;
        m_all = &m_deb;
        m_any = |m_deb;
        m_deb_prev = m_deb;
        for (int i = 0; i < N_IN; i++) begin
            age[i] = (m_s2[i] == m_s2_last[i]) ? age[i] + 1 : 1;
            if (m_s2[i] != m_deb[i] && age[i] >= DEB_LEN) m_deb[i] = m_s2[i];
        end
        m_s2_last = m_s2;
        m_s2 = m_s1;
        m_s1 = in;
        if (int'(mode) != m_state) begin
            m_state = int'(mode); c = 0; m_tick = 0;
            m_led = (mode == 2'd1) ? N_LED'(1) : '0;
        end else begin
            c++;
            m_tick = (c % PRESC == 0);
            k = c / PRESC;
            case (m_state)
                0: m_led = N_LED'(k % (1 << N_LED));
                1: m_led = N_LED'(1 << (k % N_LED));
                2: m_led = deb_old[N_LED-1:0];
                default: begin
                    ph = (k - 1) % 8;
                    m_led = (k > 0 && (ph == 0 || ph == 2)) ? '1 : '0;
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [N_IN-1:0] i, input logic [1:0] m);
        rst = r; in = i; mode = m;
        @(posedge clk);
        model_edge();
        #1;
        chk("all_hi", 32'(all_hi), 32'(m_all));
        chk("any_hi", 32'(any_hi), 32'(m_any));
        chk("rise_evt", 32'(rise_evt), 32'(m_rise));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("led", 32'(led), 32'(m_led));
    endtask

    initial begin
        logic [N_IN-1:0] rv;
        logic [1:0] rm;
        int hold;

        // T1: all inputs high, outputs at the 7th posedge
        step(1, '0, 2'd0);
        chk("reset_led", 32'(led), 32'd0);
        for (int e = 1; e <= 6; e++) step(0, 4'hF, 2'd0);
        chk("t1_any_before", 32'(any_hi), 32'd0);
        step(0, 4'hF, 2'd0);
        chk("t1_any", 32'(any_hi), 32'd1);
        chk("t1_all", 32'(all_hi), 32'd1);
        chk("t1_rise", 32'(rise_evt), 32'hF);
        step(0, 4'hF, 2'd0);
        chk("t1_rise_once", 32'(rise_evt), 32'h0);

        // T2: short glitch is rejected
        step(1, '0, 2'd0);
        for (int e = 0; e < 3; e++) step(0, 4'h1, 2'd0);
        for (int e = 0; e < 10; e++) begin
            step(0, 4'h0, 2'd0);
            chk("t2_any", 32'(any_hi), 32'd0);
        end

        // T3: partial pattern, then release without rise pulse
        for (int e = 0; e < 10; e++) step(0, 4'h5, 2'd0);
        chk("t3_any", 32'(any_hi), 32'd1);
        chk("t3_all", 32'(all_hi), 32'd0);
        for (int e = 0; e < 10; e++) step(0, 4'h0, 2'd0);
        chk("t3_any_off", 32'(any_hi), 32'd0);

        // T4/T5: count, walk, then heart
        step(1, '0, 2'd0);
        for (int e = 0; e < 20; e++) step(0, '0, 2'd0);
        step(1, '0, 2'd1);
        chk("t5_walk_entry", 32'(led), 32'd1);
        for (int e = 0; e < 8; e++) step(0, '0, 2'd1);
        chk("t5_walk", 32'(led), 32'd1);
        step(0, '0, 2'd3);
        chk("t5_heart_entry", 32'(led), 32'd0);
        for (int e = 0; e < 4; e++) step(0, '0, 2'd3);
        chk("t5_heart_first", 32'(led), 32'd3);
        for (int e = 0; e < 40; e++) step(0, '0, 2'd3);

        // T6: mirror, then reset mid-pattern
        for (int e = 0; e < 12; e++) step(0, 4'h6, 2'd2);
        chk("t6_mirror", 32'(led), 32'h2);
        step(1, 4'h6, 2'd0);
        chk("t6_rst_led", 32'(led), 32'd0);
        chk("t6_rst_any", 32'(any_hi), 32'd0);

        // Randomized: held input patterns of varying length, occasional mode changes and resets
        rv = '0; rm = 2'd0; hold = 0;
        for (int e = 0; e < 3000; e++) begin
            if (hold == 0) begin
                rv = N_IN'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 39) == 0) rm = 2'($urandom);
            step(($urandom_range(0, 299) == 0), rv, rm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
